// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared helpers and no-op encoding for the RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  // ceil(log2(value)), never narrower than one bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam logic NOOP_RD      = 1'b0;
  localparam logic NOOP_WR_BYTE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; winner is first valid index at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  i_valid,
  input  logic                i_en,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_id
);

  localparam int IW1 = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0] r_ptr;
  logic [IW1-1:0]      w_idx;
  logic [ID_WIDTH-1:0] w_win;
  logic [ID_WIDTH-1:0] w_ptr_next;
  logic                w_found;
  logic                w_grant_any;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the extra bit keeps the sum exact
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IW1'(k);
      if (w_idx >= IW1'(NUM_REQ)) begin
        w_idx = w_idx - IW1'(NUM_REQ);
      end
      if (!w_found && i_valid[w_idx[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[ID_WIDTH-1:0];
      end
    end
  end

  assign w_grant_any = w_found & i_en;
  assign o_id        = w_win;

  always_comb begin
    o_grant = '0;
    if (w_grant_any) begin
      o_grant[w_win] = 1'b1;
    end
  end

  assign w_ptr_next = (w_win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : (w_win + ID_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one RAM port among NUM_REQ requesters; routes reads back.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int RAM_DEPTH  = 512,
  localparam int ADDR_WIDTH = clog2_min1(RAM_DEPTH),
  localparam int WREN_WIDTH = (DATA_WIDTH + 7) / 8,
  localparam int ID_WIDTH   = clog2_min1(NUM_REQ)
) (
  input  logic                             clkIn,
  input  logic                             rstIn,
  input  logic                             arbEnIn,
  input  logic [NUM_REQ-1:0]               reqValidIn,
  input  logic [NUM_REQ-1:0]               reqRdIn,
  input  logic [NUM_REQ*WREN_WIDTH-1:0]    reqWrEnIn,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    reqAddrIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqWrDataIn,
  output logic [NUM_REQ-1:0]               reqReadyOut,
  output logic [NUM_REQ-1:0]               rspValidOut,
  output logic [DATA_WIDTH-1:0]            rspDataOut,
  output logic [ADDR_WIDTH-1:0]            ramAddrOut,
  output logic [WREN_WIDTH-1:0]            ramWrEnOut,
  output logic [DATA_WIDTH-1:0]            ramWrDataOut,
  output logic                             ramRdEnOut,
  input  logic [DATA_WIDTH-1:0]            ramRdDataIn,
  input  logic                             ramRdAckIn,
  output logic                             busyOut
);

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_win;
  logic                  w_grant_any;
  logic                  w_sel_rd;
  logic [WREN_WIDTH-1:0] w_sel_wr_en;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wr_data;

  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [WREN_WIDTH-1:0] r_ram_wr_en;
  logic [DATA_WIDTH-1:0] r_ram_wr_data;
  logic                  r_ram_rd_en;
  logic                  r_s1_valid;
  logic [ID_WIDTH-1:0]   r_s1_id;
  logic                  r_s2_valid;
  logic [ID_WIDTH-1:0]   r_s2_id;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .clk     (clkIn),
    .rst_n   (rstIn),
    .i_valid (reqValidIn),
    .i_en    (arbEnIn),
    .o_grant (w_grant),
    .o_id    (w_win)
  );

  assign w_grant_any = |w_grant;
  assign reqReadyOut = w_grant & {NUM_REQ{rstIn}};

  always_comb begin
    w_sel_rd      = 1'b0;
    w_sel_wr_en   = '0;
    w_sel_addr    = '0;
    w_sel_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_WIDTH'(i)) begin
        w_sel_rd      = reqRdIn[i];
        w_sel_wr_en   = reqWrEnIn[i*WREN_WIDTH +: WREN_WIDTH];
        w_sel_addr    = reqAddrIn[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wr_data = reqWrDataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Idle cycles drop the strobes but keep address/data stable on the port
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      r_ram_addr    <= '0;
      r_ram_wr_data <= '0;
      r_ram_wr_en   <= '0;
      r_ram_rd_en   <= 1'b0;
    end else if (w_grant_any) begin
      r_ram_addr    <= w_sel_addr;
      r_ram_wr_data <= w_sel_wr_data;
      r_ram_wr_en   <= w_sel_wr_en;
      r_ram_rd_en   <= w_sel_rd;
    end else begin
      r_ram_wr_en   <= {WREN_WIDTH{NOOP_WR_BYTE}};
      r_ram_rd_en   <= NOOP_RD;
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
    end else begin
      r_s1_valid <= w_grant_any & w_sel_rd;
      r_s1_id    <= w_win;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
    end
  end

  always_comb begin
    rspValidOut = '0;
    if (r_s2_valid && ramRdAckIn && rstIn) begin
      rspValidOut[r_s2_id] = 1'b1;
    end
  end

  assign rspDataOut   = ramRdDataIn;
  assign ramAddrOut   = r_ram_addr;
  assign ramWrEnOut   = r_ram_wr_en;
  assign ramWrDataOut = r_ram_wr_data;
  assign ramRdEnOut   = r_ram_rd_en;
  assign busyOut      = (|r_ram_wr_en) | r_ram_rd_en | r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed bench with read-response scoreboard and RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int WW = 4;

  logic             clk;
  logic             rstIn;
  logic             arbEnIn;
  logic [NR-1:0]    reqValidIn;
  logic [NR-1:0]    reqRdIn;
  logic [NR*WW-1:0] reqWrEnIn;
  logic [NR*AW-1:0] reqAddrIn;
  logic [NR*DW-1:0] reqWrDataIn;
  logic [NR-1:0]    reqReadyOut;
  logic [NR-1:0]    rspValidOut;
  logic [DW-1:0]    rspDataOut;
  logic [AW-1:0]    ramAddrOut;
  logic [WW-1:0]    ramWrEnOut;
  logic [DW-1:0]    ramWrDataOut;
  logic             ramRdEnOut;
  logic [DW-1:0]    ramRdDataIn;
  logic             ramRdAckIn;
  logic             busyOut;

  logic [DW-1:0]    mem [512];
  logic [DW-1:0]    ram_rd;
  logic             ram_ack;
  logic             ack_force;

  typedef struct {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;

  ram_port_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (512)
  ) dut (
    .clkIn        (clk),
    .rstIn        (rstIn),
    .arbEnIn      (arbEnIn),
    .reqValidIn   (reqValidIn),
    .reqRdIn      (reqRdIn),
    .reqWrEnIn    (reqWrEnIn),
    .reqAddrIn    (reqAddrIn),
    .reqWrDataIn  (reqWrDataIn),
    .reqReadyOut  (reqReadyOut),
    .rspValidOut  (rspValidOut),
    .rspDataOut   (rspDataOut),
    .ramAddrOut   (ramAddrOut),
    .ramWrEnOut   (ramWrEnOut),
    .ramWrDataOut (ramWrDataOut),
    .ramRdEnOut   (ramRdEnOut),
    .ramRdDataIn  (ramRdDataIn),
    .ramRdAckIn   (ramRdAckIn),
    .busyOut      (busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM: one cycle from read enable to data + ack
  always @(posedge clk) begin
    ram_ack <= ramRdEnOut;
    if (ramRdEnOut) ram_rd <= mem[ramAddrOut];
    for (int b = 0; b < WW; b++) begin
      if (ramWrEnOut[b]) mem[ramAddrOut][8*b +: 8] <= ramWrDataOut[8*b +: 8];
    end
  end

  assign ramRdDataIn = ram_rd;
  assign ramRdAckIn  = ram_ack | ack_force;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [NR-1:0] oh, input logic [DW-1:0] data);
    exp_t e;
    e.oh   = oh;
    e.data = data;
    e.cyc  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic clr_all();
    reqValidIn  = '0;
    reqRdIn     = '0;
    reqWrEnIn   = '0;
    reqAddrIn   = '0;
    reqWrDataIn = '0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic [WW-1:0] we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValidIn[i]           = 1'b1;
    reqRdIn[i]              = rd;
    reqWrEnIn[i*WW +: WW]   = we;
    reqAddrIn[i*AW +: AW]   = a;
    reqWrDataIn[i*DW +: DW] = d;
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every presented response must match the queue head, on time
  always @(negedge clk) begin : mon
    exp_t e;
    if (rspValidOut !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got %b expected none", rspValidOut);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(rspValidOut), 64'(e.oh));
        chk("rsp_data", 64'(rspDataOut), 64'(e.data));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing got none expected %b at cycle %0d", sb[0].oh, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  logic [NR-1:0] t2_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int            t4_id  [3] = '{0, 2, 3};
  logic [NR-1:0] t4_oh  [3] = '{4'b0001, 4'b0100, 4'b1000};
  logic [DW-1:0] t4_dat [3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};

  initial begin
    checks    = 0;
    errors    = 0;
    rstIn     = 1'b0;
    arbEnIn   = 1'b1;
    ack_force = 1'b0;
    clr_all();
    set_req(0, 1'b1, 4'h0, 9'h000, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(reqReadyOut), 64'h0);
    chk("rst_rden", 64'(ramRdEnOut), 64'h0);
    chk("rst_wren", 64'(ramWrEnOut), 64'h0);
    chk("rst_busy", 64'(busyOut), 64'h0);

    // Single requester write then read; first grant in first released cycle
    drive();
    rstIn = 1'b1;
    clr_all();
    set_req(1, 1'b0, 4'hF, 9'h005, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_wr_ready", 64'(reqReadyOut), 64'b0010);
    drive();
    clr_all();
    set_req(1, 1'b1, 4'h0, 9'h005, 32'h0);
    @(negedge clk);
    chk("t1_rd_ready", 64'(reqReadyOut), 64'b0010);
    chk("t1_wr_cmd_en", 64'(ramWrEnOut), 64'hF);
    chk("t1_wr_cmd_data", 64'(ramWrDataOut), 64'hDEADBEEF);
    push(4'b0010, 32'hDEADBEEF);
    drive();
    clr_all();
    @(negedge clk);
    chk("t1_rden", 64'(ramRdEnOut), 64'h1);
    chk("t1_rd_addr", 64'(ramAddrOut), 64'h005);
    chk("t1_busy", 64'(busyOut), 64'h1);
    repeat (3) drive();

    // All four continuously valid from ptr=0
    rstIn = 1'b0;
    drive();
    rstIn = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'h0, 9'h000, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t2_grant%0d", k), 64'(reqReadyOut), 64'(t2_exp[k]));
      drive();
    end
    clr_all();
    @(negedge clk);
    chk("t2_noop_busy", 64'(busyOut), 64'h0);

    // Byte-enable merge
    drive();
    set_req(2, 1'b0, 4'hF, 9'h010, 32'h11223344);
    @(negedge clk);
    chk("t3_wr1_ready", 64'(reqReadyOut), 64'b0100);
    drive();
    set_req(2, 1'b0, 4'b0100, 9'h010, 32'h00AA0000);
    @(negedge clk);
    chk("t3_wr2_ready", 64'(reqReadyOut), 64'b0100);
    drive();
    set_req(2, 1'b1, 4'h0, 9'h010, 32'h0);
    @(negedge clk);
    chk("t3_rd_ready", 64'(reqReadyOut), 64'b0100);
    push(4'b0100, 32'h11AA3344);
    drive();
    clr_all();
    repeat (3) drive();

    // Back-to-back reads from three requesters
    for (int k = 0; k < 3; k++) begin
      clr_all();
      set_req(t4_id[k], 1'b0, 4'hF, AW'(k + 1), t4_dat[k]);
      @(negedge clk);
      chk($sformatf("t4_wr_ready%0d", k), 64'(reqReadyOut), 64'(t4_oh[k]));
      drive();
    end
    for (int k = 0; k < 3; k++) begin
      clr_all();
      set_req(t4_id[k], 1'b1, 4'h0, AW'(k + 1), 32'h0);
      @(negedge clk);
      chk($sformatf("t4_rd_ready%0d", k), 64'(reqReadyOut), 64'(t4_oh[k]));
      push(t4_oh[k], t4_dat[k]);
      drive();
    end
    clr_all();
    repeat (3) drive();

    // Quiesce with requests pending
    set_req(0, 1'b1, 4'h0, 9'h001, 32'h0);
    @(negedge clk);
    chk("t5_pre_ready", 64'(reqReadyOut), 64'b0001);
    push(4'b0001, 32'hCAFE0001);
    drive();
    clr_all();
    arbEnIn = 1'b0;
    set_req(1, 1'b0, 4'h0, 9'h000, 32'h0);
    set_req(3, 1'b0, 4'h0, 9'h000, 32'h0);
    @(negedge clk);
    chk("t5_q_ready0", 64'(reqReadyOut), 64'h0);
    chk("t5_q_busy_on", 64'(busyOut), 64'h1);
    drive();
    @(negedge clk);
    chk("t5_q_ready1", 64'(reqReadyOut), 64'h0);
    drive();
    @(negedge clk);
    chk("t5_q_ready2", 64'(reqReadyOut), 64'h0);
    chk("t5_q_busy_fall", 64'(busyOut), 64'h0);

    // Reset between a read grant and its response
    drive();
    arbEnIn = 1'b1;
    clr_all();
    set_req(2, 1'b1, 4'h0, 9'h002, 32'h5555AAAA);
    @(negedge clk);
    chk("t5_rd_ready", 64'(reqReadyOut), 64'b0100);
    drive();
    clr_all();
    arbEnIn = 1'b0;
    set_req(1, 1'b0, 4'h0, 9'h000, 32'h0);
    set_req(3, 1'b0, 4'h0, 9'h000, 32'h0);
    @(negedge clk);
    chk("t5_rd_issued", 64'(ramRdEnOut), 64'h1);
    drive();
    rstIn   = 1'b0;
    arbEnIn = 1'b1;
    @(negedge clk);
    chk("t5_stray_ack", 64'(ramRdAckIn), 64'h1);
    chk("t5_rst_rsp", 64'(rspValidOut), 64'h0);
    chk("t5_rst_ready", 64'(reqReadyOut), 64'h0);
    chk("t5_rst_addr", 64'(ramAddrOut), 64'h0);
    chk("t5_rst_wdata", 64'(ramWrDataOut), 64'h0);
    chk("t5_rst_wren", 64'(ramWrEnOut), 64'h0);
    chk("t5_rst_rden", 64'(ramRdEnOut), 64'h0);
    chk("t5_rst_busy", 64'(busyOut), 64'h0);
    drive();
    rstIn     = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    chk("t5_post_ready", 64'(reqReadyOut), 64'b0010);
    chk("t5_post_rsp", 64'(rspValidOut), 64'h0);
    drive();
    ack_force = 1'b0;
    clr_all();
    repeat (4) drive();

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between NUM_REQ independent requesters, such as the CPU load/store path, the accelerator engines and the DMA.
- Round-robin arbitration with a valid/ready handshake on the requester side.
- Issues registered commands to the RAM port and routes each read response back to the requester that issued it.
- One instance sits in front of each RAM port that needs sharing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, RAM data width.
- RAM_DEPTH, 512, RAM words; ADDR_WIDTH = clog2(RAM_DEPTH).
- Derived: WREN_WIDTH = (DATA_WIDTH+7)/8; ID_WIDTH = clog2(NUM_REQ), minimum 1.

Ports:
- clkIn  in  1  clock
- rstIn  in  1  reset, asynchronous, active-low
- arbEnIn  in  1  1 = grants allowed; 0 = quiesce, no new grants
- reqValidIn  in  NUM_REQ  per-requester request valid
- reqRdIn  in  NUM_REQ  per-requester read flag
- reqWrEnIn  in  NUM_REQ*WREN_WIDTH  per-requester byte write enables (slice i = requester i)
- reqAddrIn  in  NUM_REQ*ADDR_WIDTH  per-requester address
- reqWrDataIn  in  NUM_REQ*DATA_WIDTH  per-requester write data
- reqReadyOut  out  NUM_REQ  one-hot grant
- rspValidOut  out  NUM_REQ  one-hot read response valid
- rspDataOut  out  DATA_WIDTH  read data, shared by all requesters
- ramAddrOut  out  ADDR_WIDTH  to RAM port address
- ramWrEnOut  out  WREN_WIDTH  to RAM port byte write enables
- ramWrDataOut  out  DATA_WIDTH  to RAM port write data
- ramRdEnOut  out  1  to RAM port read enable
- ramRdDataIn  in  DATA_WIDTH  from RAM port read data
- ramRdAckIn  in  1  from RAM port read ack
- busyOut  out  1  a command or read is in flight

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where reqValidIn[i] and reqReadyOut[i] are both high.
  - Once raised, a requester holds valid and payload until it is granted.
  - reqValidIn must not depend on reqReadyOut; reqReadyOut is combinational from reqValidIn, the pointer and arbEnIn.
  - A requested operation is a read if reqRdIn[i]=1, a write if reqWrEnIn slice is non-zero, or both.
  - Valid with neither read nor write is accepted and issues a no-op.
- Arbitration:
  - The winner is the first valid index at or after ptr, wrapping modulo NUM_REQ.
  - At most one ready bit is high per cycle.
  - On a grant, ptr <= winner+1 (mod NUM_REQ). With no grant, ptr holds.
  - When arbEnIn=0, reqReadyOut=0 and ptr holds.
- Command stage: on the clock edge after a grant, ramAddrOut, ramWrDataOut, ramWrEnOut and ramRdEnOut register the winner's payload. Full throughput is one command per cycle.
- Idle cycle: ramWrEnOut=0 and ramRdEnOut=0; address and data hold their last values.
- ID pipeline:
  - Two stages of {valid, ID}; stage 1 is loaded on a granted read.
  - At T+2, rspValidOut[id] = stage2.valid & ramRdAckIn, and rspDataOut = ramRdDataIn (combinational).
  - Read latency is exactly 2 cycles from grant to response.
- Read+write in one request: both are issued together and the response is still returned. Its data is unspecified and must not be relied on.
- busyOut = ramWrEnOut≠0 | ramRdEnOut | stage1.valid | stage2.valid.
- Reset (rstIn=0, asynchronous):
  - ptr=0, ramAddrOut=0, ramWrDataOut=0, ramWrEnOut=0, ramRdEnOut=0, both ID stages invalid.
  - reqReadyOut and rspValidOut are forced to 0 while reset is asserted; rspDataOut follows ramRdDataIn.
- Reset mid-operation: in-flight reads are dropped. A stray ramRdAckIn after reset (the RAM ack reset is synchronous) produces no rspValidOut.
- Deassertion: the first grant is possible in the first cycle with rstIn=1.

Decomposition:
- Package ram_arb_pkg: the derived-width helper (clog2 with minimum 1) and the no-op encoding (WrEn=0, Rd=0).
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: valid vector, enable.
  - Outputs: one-hot grant and encoded winner ID.
  - Owns the pointer register with the same asynchronous active-low reset.
- The top module holds the command registers, the ID pipeline and the response routing.

Test Plan:
1. Single requester: req1 writes addr 0x005 data 0xDEADBEEF, WrEn=4'hF; next cycle req1 reads 0x005. Required: ready[1] on both cycles, ramRdEnOut the cycle after the read grant, rspValidOut=4'b0010 with 0xDEADBEEF exactly 2 cycles after the read grant.
2. All four requesters valid continuously with ptr=0. Required: grant order 0,1,2,3,0,... with one grant per cycle and no requester starved for more than 3 cycles.
3. Byte enables: write 0x11223344 then write WrEn=4'b0100 data 0x00AA0000 to the same address, then read. Required: rspDataOut = 0x11AA3344.
4. Back-to-back reads from req0 (addr 1), req2 (addr 2), req3 (addr 3) on consecutive cycles. Required: rspValidOut = 0001, 0100, 1000 on consecutive cycles with the correct data.
5. Quiesce and reset: set arbEnIn=0 with valid pending. Required: no ready and busyOut falls within 2 cycles. Then assert rstIn low between a read grant and its response. Required: no rspValidOut, all RAM outputs 0, and after release the first grant goes to the lowest valid index.
